grant_arbiter_8: RTL and testbench
==================================

# grant_arbiter_8

Eight-requester bus arbiter that shares one resource port among requesters `req[7:0]`. It uses the team's highest-index-wins priority scheme. A grant is registered and held until the owner signals `done`, drops its request, or hits a hold timeout. There is one mandatory idle cycle between grants. It sits between the requester array and the shared datapath, and drives the resource's select from `gnt_id`.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held. 0 disables the timeout. Legal range is 0–255.
- `clk  input  1`: rising-edge clock.
- `rst  input  1`: asynchronous, active-high reset.
- `req  input  8`: request vector, bit i = requester i.
- `done  input  1`: current owner finished; sampled only while a grant is active.
- `gnt  output  8`: one-hot grant, all-zero when idle.
- `gnt_id  output  3`: binary index of the granted requester. Holds its last value while idle.
- `gnt_valid  output  1`: a grant is active; equals `|gnt`.
- `timeout  output  1`: one-cycle pulse in the cycle after a grant is forcibly released by the hold limit.

## Operation
- Reset values, all asynchronous:
  - state = IDLE
  - `gnt` = 8'h00, `gnt_id` = 3'd0, `gnt_valid` = 0, `timeout` = 0
  - hold counter = 0
  - `last_id` = 3'd0
- **IDLE state**
  - If `req` != 0 at a rising edge, register the winner into `gnt` / `gnt_id`, set `gnt_valid`, clear the hold counter, and go to GRANT.
  - If `req` == 0, stay in IDLE.
- **Winner selection, fixed priority (default):** highest set index of `req` wins, e.g. 8'b0010_0110 → id 5.
- **GRANT state**
  - The hold counter increments each cycle.
  - Release happens at the first rising edge where any of these is true:
    - `done` = 1
    - `req[gnt_id]` = 0
    - `MAX_HOLD` != 0 and counter == `MAX_HOLD`-1
  - On release: `gnt` ← 0, `gnt_valid` ← 0, `last_id` ← `gnt_id`, go to IDLE.
  - If the release was caused by the timeout alone (neither `done` nor a request drop in that cycle), `timeout` ← 1 for exactly one cycle.
- **Request changes during GRANT:** changes to other `req` bits are ignored. There is no preemption, even by a higher index.
- **Simultaneous release conditions:** `done` and timeout in the same cycle count as a normal release, so `timeout` stays 0.
- **Counter width:** `$clog2(MAX_HOLD+1)`, minimum 1 bit. The counter never wraps, because release occurs at `MAX_HOLD`-1.
- **Reset mid-grant:** immediate return to the reset values. Nothing about the interrupted grant is retained.
- **Invariants:** `gnt` is always zero or one-hot, and `gnt[gnt_id]` == `gnt_valid`.

## Timing
- **Grant latency:** 1 cycle. `req` sampled at edge t gives `gnt` valid after edge t.
- **Grant length:** minimum 1 cycle. It can be released at the first edge after the grant if `done` is high.
- **Timeout grant length:** exactly `MAX_HOLD` cycles.
- **Dead cycle:** there is always at least one IDLE cycle with `gnt` = 0 between consecutive grants. Throughput is at most one grant per 2 cycles.
- **Combinational paths:** all outputs are registered. There are no combinational input-to-output paths.

## Configuration
- **`GRANT_ARB_RR_EN` defined:** round-robin selection.
  - The search starts at index (`last_id`-1) mod 8 and descends with wrap-around. The first set bit wins.
  - After reset (`last_id` = 0) the search order is 7..0, identical to fixed priority.
  - The requester just served becomes lowest priority.
- **`GRANT_ARB_RR_EN` undefined:**
  - Fixed highest-index priority.
  - `last_id` is still updated but does not affect selection.
  - Starvation of low indices is permitted.

## Test plan
- **Single request:** reset, `req` = 8'h04 → after the next edge, `gnt` = 8'h04, `gnt_id` = 2, `gnt_valid` = 1. Pulse `done` → `gnt` = 0 the following cycle.
- **Contention, fixed priority:** `req` = 8'hA1 held constant with `done` pulsed each grant → grant ids 7, 7, 7, … with one zero cycle between grants.
- **Contention, round-robin** (`GRANT_ARB_RR_EN` defined): same stimulus → grant ids 7, 5, 0, 7, 5, … with a dead cycle between each.
- **Timeout:** `MAX_HOLD` = 4, `req` = 8'h10 held, `done` = 0 → `gnt` = 8'h10 for exactly 4 cycles, then 0. `timeout` = 1 for one cycle, then re-grant to id 4 on the next edge.
- **Request drop and no preemption:** grant id 2, then raise `req[7]` → `gnt` stays 8'h04. Drop `req[2]` → release, then grant id 7 two edges later.
- **Async reset mid-grant:** assert `rst` between edges while `gnt` = 8'h20 → `gnt`, `gnt_valid` and `gnt_id` go to 0 immediately without waiting for a clock. After reset release with `req` = 8'h20, the grant reappears after one edge.

Source files
------------

// File: rtl/grant_arbiter_8_if.sv
// Requester-side bus for grant_arbiter_8: request/done in, one-hot grant,
// grant index, grant-valid and timeout pulse out.
interface grant_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/grant_arbiter_8.sv
// Eight-requester arbiter with registered grant, hold timeout and a dead cycle.
// Optional macro GRANT_ARB_RR_EN selects round-robin instead of fixed high-index priority.
module grant_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  grant_arbiter_8_if.slave bus
);

  localparam int CW_RAW = $clog2(MAX_HOLD + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam bit TO_EN  = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = TO_EN ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_p0, state_nx;
  logic [7:0]    gnt_p0, gnt_nx;
  logic [2:0]    gnt_id_p0, gnt_id_nx;
  logic          gnt_valid_p0, gnt_valid_nx;
  logic          timeout_p0, timeout_nx;
  logic [CW-1:0] cnt_p0, cnt_nx;
  logic [2:0]    last_id_p0, last_id_nx;
  logic [2:0]    winner;
  logic          rel_drop, rel_to;

`ifdef GRANT_ARB_RR_EN
  // Descending search from last_id-1 with wrap; the lowest k that hits wins.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    pick = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = last - 3'd1 - 3'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign winner = pick(bus.req, last_id_p0);
`else
  function automatic logic [2:0] pick(input logic [7:0] r);
    pick = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) pick = 3'(i);
    end
  endfunction

  assign winner = pick(bus.req);
`endif

  assign rel_drop = ~bus.req[gnt_id_p0];
  assign rel_to   = TO_EN && (cnt_p0 == HOLD_LAST);

  always_comb begin
    state_nx     = state_p0;
    gnt_nx       = gnt_p0;
    gnt_id_nx    = gnt_id_p0;
    gnt_valid_nx = gnt_valid_p0;
    timeout_nx   = 1'b0;
    cnt_nx       = cnt_p0;
    last_id_nx   = last_id_p0;
    case (state_p0)
      IDLE: begin
        if (bus.req != 8'h00) begin
          state_nx     = GRANT;
          gnt_nx       = 8'h01 << winner;
          gnt_id_nx    = winner;
          gnt_valid_nx = 1'b1;
          cnt_nx       = '0;
        end
      end
      GRANT: begin
        if (bus.done || rel_drop || rel_to) begin
          state_nx     = IDLE;
          gnt_nx       = 8'h00;
          gnt_valid_nx = 1'b0;
          last_id_nx   = gnt_id_p0;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_nx   = rel_to && !bus.done && !rel_drop;
        end else if (TO_EN) begin
          cnt_nx = cnt_p0 + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: every output and all arbitration state are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0     <= IDLE;
      gnt_p0       <= 8'h00;
      gnt_id_p0    <= 3'd0;
      gnt_valid_p0 <= 1'b0;
      timeout_p0   <= 1'b0;
      cnt_p0       <= '0;
      last_id_p0   <= 3'd0;
    end else begin
      state_p0     <= state_nx;
      gnt_p0       <= gnt_nx;
      gnt_id_p0    <= gnt_id_nx;
      gnt_valid_p0 <= gnt_valid_nx;
      timeout_p0   <= timeout_nx;
      cnt_p0       <= cnt_nx;
      last_id_p0   <= last_id_nx;
    end
  end

  assign bus.gnt       = gnt_p0;
  assign bus.gnt_id    = gnt_id_p0;
  assign bus.gnt_valid = gnt_valid_p0;
  assign bus.timeout   = timeout_p0;

endmodule

// File: tb/tb_grant_arbiter_8.sv
// Scoreboard bench for grant_arbiter_8 (MAX_HOLD = 4): stimulus pushes expected
// post-edge outputs, a monitor pops and compares one record per clock.
module tb_grant_arbiter_8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  grant_arbiter_8_if bus ();

  grant_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {gnt, gnt_id, gnt_valid, timeout}
  logic [12:0] exp_q[$];

  task automatic compare(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
               name, act[12:5], act[4:2], act[1], act[0],
               exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // One cycle: drive inputs at the falling edge, expect outputs after the next rising edge.
  task automatic step(input logic [7:0] r, input logic d,
                      input logic [7:0] g, input logic [2:0] id, input logic to);
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    exp_q.push_back({g, id, (g != 8'h00), to});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(negedge clk);
    compare("reset_state", 13'h0);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      compare("cycle", e);
      checks++;
      if (bus.gnt_valid !== (bus.gnt != 8'h00) || (bus.gnt & (bus.gnt - 8'h01)) != 8'h00) begin
        errors++;
        $display("FAIL onehot: got gnt=%h vld=%b, want one-hot gnt matching vld",
                 bus.gnt, bus.gnt_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #12;
    compare("reset_async", 13'h0);
    do_reset();

    // Single request, released by done
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
    step(8'h04, 1'b1, 8'h00, 3'd2, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd2, 1'b0);

    // Contention on 8'hA1 from a fresh reset
    do_reset();
`ifdef GRANT_ARB_RR_EN
    step(8'hA1, 1'b0, 8'h80, 3'd7, 1'b0);
    step(8'hA1, 1'b1, 8'h00, 3'd7, 1'b0);
    step(8'hA1, 1'b0, 8'h20, 3'd5, 1'b0);
    step(8'hA1, 1'b1, 8'h00, 3'd5, 1'b0);
    step(8'hA1, 1'b0, 8'h01, 3'd0, 1'b0);
    step(8'hA1, 1'b1, 8'h00, 3'd0, 1'b0);
    step(8'hA1, 1'b0, 8'h80, 3'd7, 1'b0);
    step(8'hA1, 1'b1, 8'h00, 3'd7, 1'b0);
`else
    for (int n = 0; n < 4; n++) begin
      step(8'hA1, 1'b0, 8'h80, 3'd7, 1'b0);
      step(8'hA1, 1'b1, 8'h00, 3'd7, 1'b0);
    end
`endif
    step(8'h00, 1'b0, 8'h00, 3'd7, 1'b0);

    // Hold timeout: four grant cycles, one-cycle timeout pulse, re-grant
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    for (int n = 0; n < 3; n++) step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    step(8'h10, 1'b0, 8'h00, 3'd4, 1'b1);
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    step(8'h10, 1'b1, 8'h00, 3'd4, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd4, 1'b0);

    // done coinciding with the hold limit is a normal release
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    for (int n = 0; n < 3; n++) step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    step(8'h10, 1'b1, 8'h00, 3'd4, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd4, 1'b0);

    // No preemption, then release on request drop
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
    step(8'h84, 1'b0, 8'h04, 3'd2, 1'b0);
    step(8'h80, 1'b0, 8'h00, 3'd2, 1'b0);
    step(8'h80, 1'b0, 8'h80, 3'd7, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd7, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd7, 1'b0);

    // Asynchronous reset in the middle of a grant
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    compare("reset_mid_grant", 13'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({8'h20, 3'd5, 1'b1, 1'b0});
    step(8'h20, 1'b1, 8'h00, 3'd5, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd5, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
